// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage core.
// Arbitrates stall requests, sequences taken jumps (including redirects
// that must wait for an outstanding fetch), and keeps performance
// counters plus a MEM-bus timeout watchdog.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module pipe_ctrl #(
   parameter int BUS_TIMEOUT = 255,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   stallreq_id_in,
   input  logic                   stallreq_exe_in,
   input  logic                   stallreq_if_in,
   input  logic                   stallreq_mem_in,
   input  logic                   jump_in,
   input  logic [`ADDR_WIDTH-1:0] jump_addr_in,
   output logic [5:0]             stall_out,
   output logic                   jump_flush_out,
   output logic                   pc_redirect_out,
   output logic [`ADDR_WIDTH-1:0] pc_redirect_addr_out,
   output logic [CNT_WIDTH-1:0]   stall_cycles_out,
   output logic [CNT_WIDTH-1:0]   flush_count_out,
   output logic                   bus_timeout_out
);

   // Watchdog counter only needs to reach BUS_TIMEOUT, where it saturates.
   localparam int              WD_W   = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(BUS_TIMEOUT);

   // Stall patterns: bit0=PC .. bit5=WB, 1 = stop that stage.
   localparam logic [5:0] STALL_MEM = 6'b011111;
   localparam logic [5:0] STALL_EXE = 6'b001111;
   localparam logic [5:0] STALL_ID  = 6'b000111;
   localparam logic [5:0] STALL_IF  = 6'b000011;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t                 state_q;
   logic [`ADDR_WIDTH-1:0] redirect_q;
   logic [WD_W-1:0]        wd_cnt_q;
   logic                   accept;

   // Combinational stall/flush arbitration; everything is forced low in reset.
   always_comb begin
      stall_out            = 6'b0;
      jump_flush_out       = 1'b0;
      pc_redirect_out      = 1'b0;
      pc_redirect_addr_out = '0;
      accept               = 1'b0;
      if (!reset_in) begin
         if (state_q == DRAIN) begin
            // Redirect is pending behind an outstanding fetch; keep the
            // flush asserted and present the latched target.
            jump_flush_out       = 1'b1;
            pc_redirect_out      = 1'b1;
            pc_redirect_addr_out = redirect_q;
            stall_out            = stallreq_mem_in ? STALL_MEM
                                                   : {4'b0, stallreq_if_in, stallreq_if_in};
         end else if (jump_in && !stallreq_mem_in && !stallreq_exe_in) begin
            // Accepted jump: the ID request is dropped so the flush of
            // ID_EXE can never be masked by an ID stall.
            accept               = 1'b1;
            jump_flush_out       = 1'b1;
            pc_redirect_out      = 1'b1;
            pc_redirect_addr_out = jump_addr_in;
            stall_out            = {4'b0, stallreq_if_in, stallreq_if_in};
         end else if (stallreq_mem_in) begin
            stall_out = STALL_MEM;
         end else if (stallreq_exe_in) begin
            stall_out = STALL_EXE;
         end else if (stallreq_id_in) begin
            stall_out = STALL_ID;
         end else if (stallreq_if_in) begin
            stall_out = STALL_IF;
         end
      end
   end

   // Redirect sequencer: latch the target and wait out any outstanding fetch.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q    <= RUN;
         redirect_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (accept) begin
                  redirect_q <= jump_addr_in;
                  if (stallreq_if_in) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (!stallreq_if_in && !stallreq_mem_in) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Performance counters; both wrap freely.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         stall_cycles_out <= '0;
         flush_count_out  <= '0;
      end else begin
         if (stall_out[0]) stall_cycles_out <= stall_cycles_out + CNT_WIDTH'(1);
         if (accept)       flush_count_out  <= flush_count_out + CNT_WIDTH'(1);
      end
   end

   // MEM-bus watchdog: counts consecutive MEM stall cycles, flag is sticky.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wd_cnt_q        <= '0;
         bus_timeout_out <= 1'b0;
      end else begin
         if (wd_cnt_q == WD_MAX) bus_timeout_out <= 1'b1;
         if (!stallreq_mem_in)        wd_cnt_q <= '0;
         else if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each row of stimulus pushes its expected
// outputs; the row is compared on the following falling edge.
`timescale 1ns/1ps

module tb_pipe_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst, id, exe, ifs, mem, jmp;
   logic [31:0] jaddr;
   logic [5:0]  stall;
   logic        flush, redir, tmo;
   logic [31:0] raddr, sc, fc;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic rst, id, exe, ifs, mem, jmp;
      logic [31:0] addr;
      logic [5:0] stall;
      logic fl;
      logic [31:0] raddr;
      logic acc;
   } row_t;

   logic [104:0] exp_q[$];
   logic [104:0] e_vec;
   wire  [104:0] obs = {stall, flush, redir, raddr, sc, fc, tmo};

   // Reference model state for the registered outputs.
   logic [31:0] sc_m = 0, fc_m = 0;
   int          wd_m = 0;
   logic        to_m = 1'b0;

   pipe_ctrl #(.BUS_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
      .clk_in(clk), .reset_in(rst),
      .stallreq_id_in(id), .stallreq_exe_in(exe),
      .stallreq_if_in(ifs), .stallreq_mem_in(mem),
      .jump_in(jmp), .jump_addr_in(jaddr),
      .stall_out(stall), .jump_flush_out(flush),
      .pc_redirect_out(redir), .pc_redirect_addr_out(raddr),
      .stall_cycles_out(sc), .flush_count_out(fc),
      .bus_timeout_out(tmo)
   );

   always #5 clk = ~clk;

   function automatic row_t mk(logic r, logic i, logic e, logic f, logic m, logic j,
                               logic [31:0] a, logic [5:0] s, logic fl,
                               logic [31:0] ra, logic acc);
      row_t x;
      x.rst = r; x.id = i; x.exe = e; x.ifs = f; x.mem = m; x.jmp = j; x.addr = a;
      x.stall = s; x.fl = fl; x.raddr = ra; x.acc = acc;
      return x;
   endfunction

   // Drive one cycle of stimulus and push its expected outputs.
   task automatic drive_row(input row_t r);
      @(posedge clk);
      #1;
      rst = r.rst; id = r.id; exe = r.exe; ifs = r.ifs; mem = r.mem; jmp = r.jmp; jaddr = r.addr;
      exp_q.push_back({r.stall, r.fl, r.fl, r.raddr, sc_m, fc_m, to_m});
      if (r.rst) begin
         sc_m = 0; fc_m = 0; wd_m = 0; to_m = 1'b0;
      end else begin
         if (r.stall[0]) sc_m = sc_m + 1;
         if (r.acc)      fc_m = fc_m + 1;
         if (wd_m == TO) to_m = 1'b1;
         if (!r.mem)        wd_m = 0;
         else if (wd_m < TO) wd_m = wd_m + 1;
      end
   endtask

   task automatic test_reset();
      row_t rs[$];
      rs.push_back(mk(1,1,1,1,1,1,32'h44, 6'b000000,0,32'h0,0));
      rs.push_back(mk(0,0,0,0,0,0,32'h0,  6'b000000,0,32'h0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_priority();
      row_t rs[$];
      rs.push_back(mk(0,1,1,1,0,0,0, 6'b001111,0,0,0));
      rs.push_back(mk(0,1,1,1,1,0,0, 6'b011111,0,0,0));
      rs.push_back(mk(0,0,0,0,0,0,0, 6'b000000,0,0,0));
      rs.push_back(mk(0,0,1,0,0,0,0, 6'b001111,0,0,0));
      rs.push_back(mk(0,0,0,1,0,0,0, 6'b000011,0,0,0));
      rs.push_back(mk(0,1,0,1,0,0,0, 6'b000111,0,0,0));
      rs.push_back(mk(0,0,0,0,0,0,0, 6'b000000,0,0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL priority[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_load_use();
      row_t rs[$];
      rs.push_back(mk(0,1,0,0,0,0,0, 6'b000111,0,0,0));
      rs.push_back(mk(0,0,0,0,0,0,0, 6'b000000,0,0,0));
      rs.push_back(mk(0,0,0,0,0,0,0, 6'b000000,0,0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_jump_run();
      row_t rs[$];
      rs.push_back(mk(0,0,0,0,0,1,32'h40, 6'b000000,1,32'h40,1));
      rs.push_back(mk(0,0,0,0,0,0,32'h0,  6'b000000,0,32'h0,0));
      rs.push_back(mk(0,0,0,0,0,0,32'h0,  6'b000000,0,32'h0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL jump_run[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_jump_drain();
      row_t rs[$];
      rs.push_back(mk(0,0,0,1,0,1,32'h80,  6'b000011,1,32'h80,1));
      rs.push_back(mk(0,0,0,1,0,1,32'h100, 6'b000011,1,32'h80,0));
      rs.push_back(mk(0,0,0,1,0,0,32'h0,   6'b000011,1,32'h80,0));
      rs.push_back(mk(0,0,0,0,1,0,32'h0,   6'b011111,1,32'h80,0));
      rs.push_back(mk(0,1,0,0,0,0,32'h0,   6'b000000,1,32'h80,0));
      rs.push_back(mk(0,0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL jump_drain[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_deferred();
      row_t rs[$];
      rs.push_back(mk(0,0,1,0,0,1,32'hC0, 6'b001111,0,32'h0,0));
      rs.push_back(mk(0,0,1,0,0,1,32'hC0, 6'b001111,0,32'h0,0));
      rs.push_back(mk(0,0,0,0,0,1,32'hC0, 6'b000000,1,32'hC0,1));
      rs.push_back(mk(0,0,0,0,1,1,32'hD0, 6'b011111,0,32'h0,0));
      rs.push_back(mk(0,1,0,0,0,1,32'hE0, 6'b000000,1,32'hE0,1));
      rs.push_back(mk(0,0,0,0,0,0,32'h0,  6'b000000,0,32'h0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL deferred[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_watchdog();
      row_t rs[$];
      for (int k = 0; k < 6; k++) rs.push_back(mk(0,0,0,0,1,0,0, 6'b011111,0,0,0));
      rs.push_back(mk(0,0,0,0,0,0,0, 6'b000000,0,0,0));
      rs.push_back(mk(0,0,0,0,0,0,0, 6'b000000,0,0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL watchdog[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   task automatic test_reset_mid_drain();
      row_t rs[$];
      rs.push_back(mk(0,0,0,1,0,1,32'h200, 6'b000011,1,32'h200,1));
      rs.push_back(mk(0,0,0,1,0,0,32'h0,   6'b000011,1,32'h200,0));
      rs.push_back(mk(1,0,0,1,0,1,32'h300, 6'b000000,0,32'h0,0));
      rs.push_back(mk(0,0,0,1,0,0,32'h0,   6'b000011,0,32'h0,0));
      rs.push_back(mk(0,0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0));
      foreach (rs[i]) begin
         drive_row(rs[i]);
         @(negedge clk);
         e_vec = exp_q.pop_front();
         n_cmp++;
         if (obs !== e_vec) begin n_err++; $display("FAIL reset_drain[%0d] got=%h exp=%h", i, obs, e_vec); end
      end
   endtask

   initial begin
      rst = 1'b1; id = 0; exe = 0; ifs = 0; mem = 0; jmp = 0; jaddr = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_priority();
      test_load_use();
      test_jump_run();
      test_jump_drain();
      test_deferred();
      test_watchdog();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
